// File: rtl/reg_bank_mp.sv
// reg_bank_mp: 2R/1W register bank with bypass,
// optional zero register, busy scoreboard and init sequencer.
module reg_bank_mp #(
  parameter int WIDTH    = 64,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic [AW-1:0]    a,
  input  logic [AW-1:0]    b,
  output logic [WIDTH-1:0] dataA,
  output logic [WIDTH-1:0] dataB,
  input  logic [AW-1:0]    c,
  input  logic [WIDTH-1:0] dataC,
  input  logic             write,
  input  logic             rsv,
  input  logic [AW-1:0]    rsv_addr,
  output logic             busyA,
  output logic             busyB,
  output logic             ready
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [AW-1:0]    cnt;
  logic [AW-1:0]    cnt_n;
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_n;
  logic [WIDTH-1:0] mem [DEPTH];

  logic run;
  logic byp_ok;
  logic wr_ok;
  logic rsv_ok;
  logic a_zero;
  logic b_zero;

  assign run    = (state == S_RUN);
  assign ready  = run;
  assign byp_ok = run && write
               && !(ZERO_REG && c == '0);
  assign wr_ok  = byp_ok && !clear;
  assign rsv_ok = run && rsv && !clear
               && !(ZERO_REG && rsv_addr == '0);
  assign a_zero = ZERO_REG && (a == '0);
  assign b_zero = ZERO_REG && (b == '0);

  // Sequencer state and sweep counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next state: sweep all entries, then run until clear.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    unique case (state)
      S_INIT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == LAST) begin
          state_n = S_RUN;
        end
      end
      S_RUN: begin
        if (clear) begin
          state_n = S_INIT;
          cnt_n   = '0;
        end
      end
      default: begin
        state_n = S_INIT;
        cnt_n   = '0;
      end
    endcase
  end

  // Busy update: reserve overrides a same-cycle write.
  always_comb begin
    busy_n = busy;
    if (!run) begin
      busy_n[cnt] = 1'b0;
    end else begin
      if (wr_ok) begin
        busy_n[c] = 1'b0;
      end
      if (rsv_ok) begin
        busy_n[rsv_addr] = 1'b1;
      end
    end
  end

  // Busy scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      busy <= busy_n;
    end
  end

  // Storage: zeroed by the sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[cnt] <= '0;
    end else if (wr_ok) begin
      mem[c] <= dataC;
    end
  end

  // Port A read with write bypass.
  always_comb begin
    dataA = '0;
    busyA = 1'b0;
    if (run && !a_zero) begin
      busyA = busy[a];
      if (byp_ok && c == a) begin
        dataA = dataC;
      end else begin
        dataA = mem[a];
      end
    end
  end

  // Port B read with write bypass.
  always_comb begin
    dataB = '0;
    busyB = 1'b0;
    if (run && !b_zero) begin
      busyB = busy[b];
      if (byp_ok && c == b) begin
        dataB = dataC;
      end else begin
        dataB = mem[b];
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_mp.sv
// tb_reg_bank_mp: directed and random checks of reg_bank_mp
// against an array-based reference model.
module tb_reg_bank_mp;

  localparam int W = 64;
  localparam int D = 32;
  localparam int A = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clear = 1'b0;
  logic [A-1:0] a = '0;
  logic [A-1:0] b = '0;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [A-1:0] c = '0;
  logic [W-1:0] dataC = '0;
  logic         write = 1'b0;
  logic         rsv = 1'b0;
  logic [A-1:0] rsv_addr = '0;
  logic         busyA;
  logic         busyB;
  logic         ready;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_mem [D];
  bit           m_bsy [D];
  bit           m_run;
  int           m_left;

  reg_bank_mp #(
    .WIDTH(W), .DEPTH(D), .AW(A), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .a(a), .b(b), .dataA(dataA), .dataB(dataB),
    .c(c), .dataC(dataC), .write(write),
    .rsv(rsv), .rsv_addr(rsv_addr),
    .busyA(busyA), .busyB(busyB), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic m_wipe();
    m_run  = 1'b0;
    m_left = D;
    for (int i = 0; i < D; i++) begin
      m_mem[i] = '0;
      m_bsy[i] = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] e_data(
    logic [A-1:0] ad);
    if (!m_run || ad == 0) return '0;
    if (write && c == ad) return dataC;
    return m_mem[ad];
  endfunction

  function automatic logic e_busy(logic [A-1:0] ad);
    return m_run && ad != 0 && m_bsy[ad];
  endfunction

  task automatic m_edge();
    if (!m_run) begin
      m_left--;
      if (m_left == 0) m_run = 1'b1;
    end else if (clear) begin
      m_wipe();
    end else begin
      if (write && c != 0) begin
        m_mem[c] = dataC;
        m_bsy[c] = 1'b0;
      end
      if (rsv && rsv_addr != 0) m_bsy[rsv_addr] = 1'b1;
    end
  endtask

  task automatic cyc();
    #1;
    chk("ready", W'(ready), W'(m_run));
    chk("dataA", dataA, e_data(a));
    chk("dataB", dataB, e_data(b));
    chk("busyA", W'(busyA), W'(e_busy(a)));
    chk("busyB", W'(busyB), W'(e_busy(b)));
    @(posedge clk);
    m_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    clear = 0; write = 0; rsv = 0;
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    m_wipe();
    #1;
    chk("rst_ready", W'(ready), '0);
    chk("rst_busyA", W'(busyA), '0);
    chk("rst_dataA", dataA, '0);
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic init_wait();
    for (int i = 0; i < D; i++) begin
      chk("init_ready", W'(ready), '0);
      cyc();
    end
    #1 chk("ready_up", W'(ready), W'(1));
  endtask

  initial begin
    m_wipe();
    @(negedge clk);
    do_reset(3);
    idle();
    init_wait();

    for (int i = 0; i < D; i++) begin
      a = A'(i); b = A'(D - 1 - i);
      cyc();
    end

    a = 5; c = 5; write = 1;
    dataC = 64'hDEADBEEF_00000001;
    #1 chk("bypass", dataA, 64'hDEADBEEF_00000001);
    cyc();
    write = 0;
    #1 chk("after_wr", dataA, 64'hDEADBEEF_00000001);
    cyc();

    a = 0; c = 0; write = 1; dataC = '1;
    #1 chk("zero_byp", dataA, '0);
    cyc();
    write = 0;
    #1 chk("zero_next", dataA, '0);
    cyc();
    rsv = 1; rsv_addr = 0;
    cyc();
    rsv = 0;
    #1 chk("zero_busy", W'(busyA), '0);
    cyc();

    a = 7; rsv = 1; rsv_addr = 7;
    cyc();
    rsv = 0;
    #1 chk("rsv7", W'(busyA), W'(1));
    cyc();
    write = 1; c = 7; dataC = 64'h77;
    cyc();
    write = 0;
    #1 chk("wr7_free", W'(busyA), '0);
    cyc();

    a = 9; b = 9; rsv = 1; rsv_addr = 9;
    write = 1; c = 9; dataC = 64'h1234_5678_9ABC_DEF0;
    cyc();
    idle();
    #1 chk("rw9_busy", W'(busyA), W'(1));
    chk("rw9_data", dataB, 64'h1234_5678_9ABC_DEF0);
    cyc();

    for (int i = 1; i < D; i++) begin
      write = 1; c = A'(i);
      dataC = {32'hA5A5_0000 + i, $urandom};
      a = A'(i); b = A'($urandom_range(0, D - 1));
      cyc();
    end
    write = 1; c = 3; dataC = 64'hBAD; clear = 1; a = 3;
    cyc();
    idle();
    init_wait();
    a = 3;
    #1 chk("clr_mem3", dataA, '0);
    for (int i = 0; i < D; i++) begin
      a = A'(i); b = A'(i);
      cyc();
    end

    for (int n = 0; n < 600; n++) begin
      a = A'($urandom); b = A'($urandom);
      c = A'($urandom); dataC = {$urandom, $urandom};
      write = 1'($urandom);
      rsv = 1'($urandom);
      rsv_addr = ($urandom_range(0, 3) == 0) ? c
               : A'($urandom);
      clear = ($urandom_range(0, 63) == 0);
      if (n % 50 == 0) begin
        a = c; b = c;
      end
      cyc();
    end
    idle();

    do_reset(2);
    repeat (10) cyc();
    #1 chk("mid_ready", W'(ready), '0);
    do_reset(2);
    init_wait();
    a = 9; b = 31;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_bank_mp.md
# reg_bank_mp

Parametrised successor register bank for the datapath: two combinational read ports and one write port, with a configurable data width and depth. Adds several things a plain register array lacks: write-to-read bypass, an optional hardwired zero register, and a per-entry busy scoreboard for issue logic. It also has a self-clearing init sequencer, so the storage array needs no asynchronous reset. It sits between decode/issue and the execute stage.

## Interface
- WIDTH, 64, data width in bits
- DEPTH, 32, number of entries (power of two, ≥ 2)
- AW, 5, address width; must equal log2(DEPTH)
- ZERO_REG, 1, when 1 entry 0 always reads 0, ignores writes and is never busy
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  pulse in RUN: re-enter INIT and zero the array
- a  in  AW  read port A address
- b  in  AW  read port B address
- dataA  out  WIDTH  read port A data
- dataB  out  WIDTH  read port B data
- c  in  AW  write address
- dataC  in  WIDTH  write data
- write  in  1  write enable
- rsv  in  1  reserve: mark entry rsv_addr busy
- rsv_addr  in  AW  entry to reserve
- busyA  out  1  busy bit of entry a
- busyB  out  1  busy bit of entry b
- ready  out  1  1 in RUN, 0 in INIT

## Operation
- **States:** INIT and RUN.
  - Async reset (rst_n=0) forces INIT with cnt=0, clears all busy bits, and drives ready=0.
  - The array itself is not reset asynchronously.
- **INIT:**
  - Each cycle writes 0 to mem[cnt], clears busy[cnt], then cnt += 1.
  - When cnt == DEPTH-1 has been written, go to RUN on the next edge; cnt wraps to 0.
  - INIT lasts exactly DEPTH cycles.
  - write, rsv and clear are ignored in INIT.
  - dataA, dataB, busyA and busyB are forced to 0 in INIT.
- **RUN:**
  - clear=1: go to INIT with cnt=0; the same-cycle write and rsv are discarded.
  - write=1: mem[c] ← dataC and busy[c] ← 0 at the edge.
  - rsv=1: busy[rsv_addr] ← 1 at the edge.
  - rsv and write to the same address in the same cycle: data is written and busy ends at 1 (rsv wins).
- **Reads:**
  - dataA = mem[a] combinationally.
  - Bypass: if write=1, c==a, RUN, and not (ZERO_REG && a==0), then dataA = dataC in the same cycle.
  - Port B behaves identically on b.
  - busyA and busyB reflect the registered busy bits only; they are not bypassed.
- **ZERO_REG=1:** writes and reservations to address 0 are dropped, dataA/dataB = 0 when the address is 0, and busyA/busyB = 0 when the address is 0.
- **Storage:** busy is a DEPTH-bit register with async clear; mem is DEPTH×WIDTH.

## Timing
- Read latency is 0 cycles (combinational from a/b/c/dataC/write).
- Write is visible via the array on the cycle after the edge, and same-cycle via the bypass.
- ready rises DEPTH cycles after rst_n deasserts (first edge with rst_n=1 counts as INIT cycle 0). It rises DEPTH cycles after a clear edge likewise.
- Reset values: ready=0, busyA=0, busyB=0, dataA=0, dataB=0.
- Reset asserted mid-INIT or mid-RUN: state returns to INIT immediately (async) with cnt=0, and a full clear is performed again.
- a == b is legal; both ports return the same data.

## Test plan
- **Reset/init:** rst_n low for 3 cycles, then high, DEPTH=32 → ready=0 for 32 edges, ready=1 after the 32nd; every address reads 0 and busy=0.
- **Write/read with bypass:** c=5, dataC=0xDEADBEEF_00000001, write=1, a=5 → dataA equals dataC in the same cycle. Next cycle with write=0 → dataA still 0xDEADBEEF_00000001.
- **Zero register:** write 0xFFFF... to c=0 with ZERO_REG=1 → dataA=0 at a=0 in the same and the next cycle. rsv_addr=0 → busyA=0.
- **Scoreboard:** rsv=1, rsv_addr=7 → busyA=1 (a=7) next cycle. write c=7 → busyA=0 next cycle. Same-cycle rsv and write on 9 → busy[9]=1 and mem[9]=dataC.
- **clear mid-run:** after filling entries 1..31, pulse clear together with write c=3 → ready=0 for 32 cycles, then all entries read 0 and mem[3] was not written.
- **Async reset mid-INIT:** drop rst_n at cnt=10 → ready stays 0, and the sequencer restarts at 0 for a full 32 cycles after release.
